lab2_proc_fetch_buffer: RTL and testbench

Instruction-fetch response buffer and squash/drop unit between the instruction memory response port and the D-stage instruction register of the stalling/bypassing pipelined processor. It accepts imem responses, buffers up to `p_num_entries` instructions, and presents them to decode with a val/rdy handshake. It issues request credits so the buffer can never overflow. On a control-flow squash it discards every buffered instruction and every response still in flight for the old path.

---
 rtl/lab2_proc_fetch_buffer.sv | 71 +++++++
 tb/tb_lab2_proc_fetch_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/lab2_proc_fetch_buffer.sv
// lab2_proc_fetch_buffer: imem response buffer with request credits and squash/drop of old-path responses
// Ports: clk/reset; imemreq_val/rdy in, imemreq_ok out (credit); imemresp_val/data in, imemresp_rdy out;
// squash in (redirect); inst_val/inst_data out, inst_rdy in (D-stage handshake); drop_cnt out (pending drops).
module lab2_proc_fetch_buffer #(
  parameter int p_num_entries = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 imemreq_val,
  input  logic                                 imemreq_rdy,
  output logic                                 imemreq_ok,
  input  logic                                 imemresp_val,
  output logic                                 imemresp_rdy,
  input  logic [31:0]                          imemresp_data,
  input  logic                                 squash,
  output logic                                 inst_val,
  input  logic                                 inst_rdy,
  output logic [31:0]                          inst_data,
  output logic [$clog2(p_num_entries+1)-1:0]   drop_cnt
);
  localparam int CW = $clog2(p_num_entries + 1);
  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [PW-1:0] LAST = PW'(p_num_entries - 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(p_num_entries);
  logic [CW-1:0] o_q, o_d, d_q, d_d, c_q, c_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0] mem_q [p_num_entries];
  logic req_fire, resp_fire, resp_keep, deq_buf, enq, empty;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    empty        = (c_q == '0);
    imemresp_rdy = !reset;
    req_fire     = imemreq_val & imemreq_rdy;
    resp_fire    = imemresp_val & imemresp_rdy & (o_q != '0);
    resp_keep    = resp_fire & !squash & (d_q == '0);
    imemreq_ok   = reset | (({1'b0, o_q} + {1'b0, c_q}) < LIMIT);
    drop_cnt     = reset ? '0 : d_q;
    inst_val     = !reset & !squash & (!empty | resp_keep);
    inst_data    = empty ? imemresp_data : mem_q[head_q];
    deq_buf      = inst_val & inst_rdy & !empty;
    enq          = resp_keep & !(empty & inst_rdy);
    o_d          = o_q + CW'(req_fire) - CW'(resp_fire);
    d_d          = squash ? o_q - CW'(resp_fire) : d_q - CW'(resp_fire & (d_q != '0));
    c_d          = squash ? '0 : c_q + CW'(enq) - CW'(deq_buf);
    head_d       = squash ? '0 : deq_buf ? nxt(head_q) : head_q;
    tail_d       = squash ? '0 : enq ? nxt(tail_q) : tail_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o_q    <= '0;
      d_q    <= '0;
      c_q    <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      o_q    <= o_d;
      d_q    <= d_d;
      c_q    <= c_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= imemresp_data;
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (!imemresp_val || o_q != '0) else $error("imem response with no outstanding request");
  end
endmodule

// File: tb/tb_lab2_proc_fetch_buffer.sv
// tb_lab2_proc_fetch_buffer: directed table-driven bench for the fetch buffer
module tb_lab2_proc_fetch_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imemreq_val = 1'b0, imemreq_rdy = 1'b0, imemreq_ok;
  logic imemresp_val = 1'b0, imemresp_rdy;
  logic [31:0] imemresp_data = '0;
  logic squash = 1'b0, inst_val, inst_rdy = 1'b0;
  logic [31:0] inst_data;
  logic [1:0] drop_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [5:0]  i;
    logic [31:0] d;
    logic [2:0]  e;
    logic [31:0] ed;
    logic [1:0]  dc;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  lab2_proc_fetch_buffer #(.p_num_entries(2)) dut (
    .clk(clk), .reset(reset),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_ok(imemreq_ok),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .squash(squash), .inst_val(inst_val), .inst_rdy(inst_rdy), .inst_data(inst_data),
    .drop_cnt(drop_cnt)
  );
  task automatic chk(input string nm, input string sig, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s %s got %0h expected %0h", nm, sig, got, want);
    end
  endtask
  task automatic run(input vec_t x, input string nm);
    @(negedge clk);
    {reset, imemreq_val, imemreq_rdy, imemresp_val, squash, inst_rdy} = x.i;
    imemresp_data = x.d;
    #1;
    chk(nm, "imemreq_ok", {31'b0, imemreq_ok}, {31'b0, x.e[2]});
    chk(nm, "imemresp_rdy", {31'b0, imemresp_rdy}, {31'b0, x.e[1]});
    chk(nm, "inst_val", {31'b0, inst_val}, {31'b0, x.e[0]});
    chk(nm, "drop_cnt", {30'b0, drop_cnt}, {30'b0, x.dc});
    if (x.e[0]) chk(nm, "inst_data", inst_data, x.ed);
  endtask
  task automatic add(input logic [5:0] i, input logic [31:0] d, input logic [2:0] e, input logic [31:0] ed, input logic [1:0] dc);
    vec_t v;
    v.i = i; v.d = d; v.e = e; v.ed = ed; v.dc = dc;
    tbl.push_back(v);
  endtask
  initial begin
    // inputs {reset, req_val, req_rdy, resp_val, squash, inst_rdy}; expected {ok, resp_rdy, inst_val}
    add(6'b100000, 32'h0,   3'b100, 32'h0,   2'd0);
    add(6'b000000, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011101, 32'h13,  3'b111, 32'h13,  2'd0);
    add(6'b011101, 32'h93,  3'b111, 32'h93,  2'd0);
    add(6'b011101, 32'h113, 3'b111, 32'h113, 2'd0);
    add(6'b000101, 32'h193, 3'b111, 32'h193, 2'd0);
    add(6'b000001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011000, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011100, 32'hA,   3'b111, 32'hA,   2'd0);
    add(6'b000100, 32'hB,   3'b011, 32'hA,   2'd0);
    add(6'b000000, 32'h0,   3'b011, 32'hA,   2'd0);
    add(6'b000001, 32'h0,   3'b011, 32'hA,   2'd0);
    add(6'b000001, 32'h0,   3'b111, 32'hB,   2'd0);
    add(6'b000001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b000011, 32'h0,   3'b010, 32'h0,   2'd0);
    add(6'b000001, 32'h0,   3'b010, 32'h0,   2'd2);
    add(6'b000101, 32'h111, 3'b010, 32'h0,   2'd2);
    add(6'b011101, 32'h222, 3'b110, 32'h0,   2'd1);
    add(6'b000101, 32'h6F,  3'b111, 32'h6F,  2'd0);
    add(6'b000001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011001, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011111, 32'h333, 3'b010, 32'h0,   2'd0);
    add(6'b000001, 32'h0,   3'b010, 32'h0,   2'd1);
    add(6'b000101, 32'h444, 3'b010, 32'h0,   2'd1);
    add(6'b000101, 32'h555, 3'b111, 32'h555, 2'd0);
    add(6'b011000, 32'h0,   3'b110, 32'h0,   2'd0);
    add(6'b011100, 32'h1,   3'b111, 32'h1,   2'd0);
    add(6'b000100, 32'h2,   3'b011, 32'h1,   2'd0);
    add(6'b000011, 32'h0,   3'b010, 32'h0,   2'd0);
    add(6'b000001, 32'h0,   3'b110, 32'h0,   2'd0);
    for (int k = 0; k < tbl.size(); k++) run(tbl[k], $sformatf("vec%0d", k));
    // reset with one buffered word and one request outstanding
    run('{6'b011000, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_req");
    run('{6'b011100, 32'hAB, 3'b111, 32'hAB, 2'd0}, "rst_fill");
    run('{6'b100000, 32'h0,  3'b100, 32'h0,  2'd0}, "rst_assert");
    run('{6'b000000, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_after");
    run('{6'b011000, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_newreq");
    run('{6'b000000, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_o_clear");
    // reset with a pending drop
    run('{6'b000010, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_sq");
    run('{6'b000000, 32'h0,  3'b110, 32'h0,  2'd1}, "rst_sq_dc");
    run('{6'b100000, 32'h0,  3'b100, 32'h0,  2'd0}, "rst_assert2");
    run('{6'b000000, 32'h0,  3'b110, 32'h0,  2'd0}, "rst_after2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
